sha256_padder: RTL and testbench
================================

# sha256_padder

- Converts a byte-stream message, delivered as 32-bit big-endian words, into padded 512-bit SHA-256 blocks: one 0x80 byte, then zero fill, then the 64-bit big-endian message bit length.
- Producer side of the message-schedule block interface: emits 512-bit blocks in the word order the schedule consumes (W0 in [511:480], W15 in [31:0]), with a ready/valid handshake and a final-block flag for the compression controller.

## Interface
- No parameters (block size 512, word width 32 and length field width 64 are fixed by SHA-256).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts a word when in_valid & in_ready.
- in_data  in  32  message bytes, first byte in [31:24].
- in_last  in  1  word is the last of the message.
- in_nbytes  in  3  valid bytes in a last word (0..4; 0 means no data bytes); ignored when in_last=0 (4 bytes implied); values 5..7 are illegal.
- blk_valid  out  1  blk_data holds a complete block.
- blk_ready  in  1  downstream accepts the block when blk_valid & blk_ready.
- blk_data  out  512  block, word k in [511-32k -: 32].
- blk_last  out  1  block is the final block of the message.

## Operation
- Reset (async, rst_n low): state=FILL, word index=0, bit counter=0, extra flag=0, blk_valid=0, blk_last=0, blk_data=0, in_ready=0. in_ready goes to 1 in the first cycle after rst_n deasserts.
- Reset mid-operation: the partial block, counter and any pending block are discarded; the next accepted word starts a new message.
- State FILL: in_ready=1, blk_valid=0. Each accepted word is written into buffer word index i, i increments, and the 64-bit bit counter adds 32 (non-last word) or 8*in_nbytes (last word), modulo 2^64.
  - Non-last word at i=15 -> HOLD with blk_last=0; i wraps to 0.
  - Last word -> PAD; p = 4*i + in_nbytes is the pad byte position (0..64). Unused bytes of the last word are stored as zero.
- State PAD (1 cycle): in_ready=0.
  - If p<64, byte p = 0x80; bytes after p = 0.
  - p<=55: words 14/15 = counter[63:32]/counter[31:0], blk_last=1.
  - p>=56: blk_last=0, extra=1; words 14..15 keep data/pad/zero.
  - Then -> HOLD.
- State HOLD: blk_valid=1, blk_data and blk_last stable until the handshake.
  - Handshake with extra=1: on the same edge load the extra block (byte 0 = 0x80 if p==64, else 0; bytes 1..55 zero; words 14/15 = length), set blk_last=1, clear extra, stay in HOLD. blk_valid stays high.
  - Handshake with extra=0: -> FILL, i=0. If blk_last=1, also clear the counter.
- Arithmetic: counter wraps mod 2^64. Messages of 2^61 bytes or more produce a truncated length, per the standard's limit.
- No simultaneous input and output transfers exist: in_ready and blk_valid are never high together.

## Timing
- Non-final full block: 16th word accepted at edge T -> blk_valid=1 in cycle T+1.
- Final block: last word accepted at edge T -> blk_valid=1 in cycle T+2 (PAD cycle).
- Extra block: first-block handshake at edge U -> extra block on blk_data in cycle U+1.
- After the final-block handshake at edge V: in_ready=1 in cycle V+1.
- Zero bubbles are required on the output side: blk_valid may drop only after a handshake with extra=0.
- Throughput: 16 input cycles plus 1 output cycle minimum per block with blk_ready held high.

## Test plan
- Empty message: one word with in_last=1, in_nbytes=0 -> one block; word0=0x80000000, words1..15=0, blk_last=1.
- "abc": in_data=0x61626300, in_nbytes=3, in_last=1 -> word0=0x61626380, words1..14=0, word15=0x00000018, blk_last=1; blk_valid rises exactly 2 cycles after acceptance.
- 56-byte message (14 full words, last with nbytes=4):
  - Block 1: word14=0x80000000, word15=0, blk_last=0.
  - Block 2: words0..13=0, word14=0, word15=0x000001C0, blk_last=1; presented the cycle after block 1's handshake.
- 64-byte message (16 words, last on 16th):
  - Block 1: data unchanged, blk_last=0.
  - Block 2: word0=0x80000000, word15=0x00000200, blk_last=1.
- Backpressure: hold blk_ready=0 for 10 cycles with a block pending -> in_ready=0 and blk_data/blk_last stable throughout. Then stream a 2-block (100-byte) message; word15 of the final block = 0x00000320 and no word is lost or duplicated.
- Reset after 5 words of a message, then send "abc" -> no block is emitted for the aborted message; the "abc" block matches the earlier "abc" scenario exactly (length 0x18).

Source files
------------

// File: rtl/sha256_padder.sv
// sha256_padder: packs a 32-bit big-endian byte stream into padded 512-bit SHA-256 blocks.
module sha256_padder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last
);
  typedef enum logic [1:0] {FILL, PAD, HOLD} state_t;
  state_t state, nxt;
  logic [3:0]   idx;
  logic [63:0]  cnt;
  logic         extra;
  logic [6:0]   p;
  logic         acc, hs;
  logic [31:0]  word;
  logic [511:0] pad_blk;
  assign acc = in_valid & in_ready;
  assign hs = blk_valid & blk_ready;
  assign blk_valid = state == HOLD;
  assign word = in_last ? in_data & ~(32'hFFFF_FFFF >> {in_nbytes, 3'b000}) : in_data;
  always_comb begin
    nxt = state;
    if (state == FILL && acc) nxt = in_last ? PAD : (idx == 4'd15 ? HOLD : FILL);
    else if (state == PAD) nxt = HOLD;
    else if (state == HOLD && hs && !extra) nxt = FILL;
  end
  // Bytes past the pad position are cleared so stale data from older messages never leaks.
  always_comb begin
    pad_blk = blk_data;
    for (int b = 0; b < 64; b++)
      if (7'(b) >= p) pad_blk[511-8*b -: 8] = (7'(b) == p) ? 8'h80 : 8'h00;
    if (p <= 7'd55) pad_blk[63:0] = cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      in_ready <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
      extra    <= 1'b0;
      p        <= '0;
      blk_data <= '0;
      blk_last <= 1'b0;
    end else begin
      state    <= nxt;
      in_ready <= nxt == FILL;
      if (acc) begin
        blk_data[511-32*idx -: 32] <= word;
        idx <= idx + 4'd1;
        cnt <= cnt + (in_last ? {58'd0, in_nbytes, 3'd0} : 64'd32);
        if (in_last) p <= {1'b0, idx, 2'b00} + {4'd0, in_nbytes};
        if (!in_last && idx == 4'd15) blk_last <= 1'b0;
      end
      if (state == PAD) begin
        blk_data <= pad_blk;
        blk_last <= (p <= 7'd55);
        extra    <= (p > 7'd55);
      end
      if (hs) begin
        if (extra) begin
          blk_data <= {(p == 7'd64) ? 8'h80 : 8'h00, 440'd0, cnt};
          blk_last <= 1'b1;
          extra    <= 1'b0;
        end else begin
          idx <= '0;
          if (blk_last) cnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: directed checks of sha256_padder against hand-computed padded blocks.
module tb_sha256_padder;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [2:0]   in_nbytes = '0;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [511:0] blk_data;
  logic         blk_last;
  int n_cmp = 0;
  int n_err = 0;
  logic [511:0] e, d, held;
  logic         l;
  sha256_padder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_nbytes(in_nbytes),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mk(input int i);
    return {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
  endfunction
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [31:0] dat, input logic lst, input logic [2:0] nb);
    int k = 0;
    in_valid = 1'b1; in_data = dat; in_last = lst; in_nbytes = nb;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    chk("in_timeout", 512'(k < 50), 512'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic get_blk(output logic [511:0] dat, output logic lst);
    int k = 0;
    while (!blk_valid && k < 50) begin @(posedge clk); #1; k++; end
    chk("blk_timeout", 512'(k < 50), 512'd1);
    dat = blk_data; lst = blk_last;
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_in_ready", 512'(in_ready), 512'd0);
    chk("rst_blk_valid", 512'(blk_valid), 512'd0);
    chk("rst_blk_last", 512'(blk_last), 512'd0);
    chk("rst_blk_data", blk_data, 512'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 512'(in_ready), 512'd1);
    // empty message
    send(32'h0, 1'b1, 3'd0);
    get_blk(d, l);
    chk("empty_data", d, {32'h8000_0000, 480'd0});
    chk("empty_last", 512'(l), 512'd1);
    // "abc" with latency check
    send(32'h6162_6300, 1'b1, 3'd3);
    chk("abc_pad_cycle", 512'(blk_valid), 512'd0);
    @(posedge clk); #1;
    chk("abc_valid_t2", 512'(blk_valid), 512'd1);
    get_blk(d, l);
    chk("abc_data", d, {32'h6162_6380, 448'd0, 32'h18});
    chk("abc_last", 512'(l), 512'd1);
    chk("abc_ready_after", 512'(in_ready), 512'd1);
    // 56-byte message: pad byte lands at 56, spills length into an extra block
    for (int i = 0; i < 14; i++) send(mk(i), i == 13, 3'd4);
    e = '0;
    for (int i = 0; i < 14; i++) e[511-32*i -: 32] = mk(i);
    e[63:32] = 32'h8000_0000;
    get_blk(d, l);
    chk("m56_b1_data", d, e);
    chk("m56_b1_last", 512'(l), 512'd0);
    chk("m56_b2_valid", 512'(blk_valid), 512'd1);
    chk("m56_b2_now", blk_data, {480'd0, 32'h1C0});
    get_blk(d, l);
    chk("m56_b2_data", d, {480'd0, 32'h1C0});
    chk("m56_b2_last", 512'(l), 512'd1);
    // 64-byte message
    for (int i = 0; i < 16; i++) send(mk(i), i == 15, 3'd4);
    for (int i = 0; i < 16; i++) e[511-32*i -: 32] = mk(i);
    get_blk(d, l);
    chk("m64_b1_data", d, e);
    chk("m64_b1_last", 512'(l), 512'd0);
    get_blk(d, l);
    chk("m64_b2_data", d, {32'h8000_0000, 448'd0, 32'h200});
    chk("m64_b2_last", 512'(l), 512'd1);
    // 100-byte message with 10 cycles of backpressure on the first block
    for (int i = 0; i < 16; i++) send(mk(i), 1'b0, 3'd0);
    chk("bp_valid_t1", 512'(blk_valid), 512'd1);
    held = blk_data;
    for (int i = 0; i < 16; i++) e[511-32*i -: 32] = mk(i);
    chk("bp_b1_data", held, e);
    in_valid = 1'b1; in_data = mk(16); in_last = 1'b0; in_nbytes = 3'd0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 512'(in_ready), 512'd0);
      chk("bp_data_stable", blk_data, held);
      chk("bp_last_stable", 512'(blk_last), 512'd0);
    end
    get_blk(d, l);
    chk("bp_b1_last", 512'(l), 512'd0);
    for (int i = 16; i < 25; i++) send(mk(i), i == 24, 3'd4);
    e = '0;
    for (int i = 0; i < 9; i++) e[511-32*i -: 32] = mk(16 + i);
    e[223:192] = 32'h8000_0000;
    e[31:0] = 32'h320;
    get_blk(d, l);
    chk("bp_b2_data", d, e);
    chk("bp_b2_last", 512'(l), 512'd1);
    // abort a message with reset, then "abc" again
    for (int i = 0; i < 5; i++) send(mk(i), 1'b0, 3'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_rst_ready", 512'(in_ready), 512'd0);
    chk("abort_rst_data", blk_data, 512'd0);
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready", 512'(in_ready), 512'd1);
    chk("abort_no_blk", 512'(blk_valid), 512'd0);
    send(32'h6162_6300, 1'b1, 3'd3);
    get_blk(d, l);
    chk("abort_abc_data", d, {32'h6162_6380, 448'd0, 32'h18});
    chk("abort_abc_last", 512'(l), 512'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
